// File: rtl/pattern_scan_ctrl.sv
// Raster-order coordinate sequencer for the X-step pattern datapath.
// Latches a window and X step on start, then streams (x, y) over a valid/ready handshake.
module pattern_scan_ctrl #(
  parameter int unsigned W  = 12,
  parameter int unsigned CW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  cfg_x0,
  input  logic [W-1:0]  cfg_y0,
  input  logic [W-1:0]  cfg_width,
  input  logic [W-1:0]  cfg_height,
  input  logic [1:0]    cfg_xmode,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [W-1:0]  pix_x,
  output logic [W-1:0]  pix_y,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] pix_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [W-1:0]  x0_q, x0_d;
  logic [3:0]    step_q, step_d;
  logic [W-1:0]  x_end_q, x_end_d;
  logic [W-1:0]  y_end_q, y_end_d;
  logic [W-1:0]  pix_x_q, pix_x_d;
  logic [W-1:0]  pix_y_q, pix_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          cfg_ok;
  logic [3:0]    cfg_step;
  logic [W:0]    x_sum;
  logic [W:0]    y_sum;
  logic [W-1:0]  x_end_new;
  logic [W-1:0]  y_end_new;
  logic [W:0]    x_nxt;
  logic          accept;

  assign cfg_ok = (cfg_xmode != 2'b00) && (cfg_width != '0) && (cfg_height != '0);

  always_comb begin
    cfg_step = 4'd0;
    unique case (cfg_xmode)
      2'b01:   cfg_step = 4'd1;
      2'b10:   cfg_step = 4'd4;
      2'b11:   cfg_step = 4'd8;
      default: cfg_step = 4'd0;
    endcase
  end

  // End bounds in W+1 bits; a carry out means the window runs off the coordinate space.
  assign x_sum     = {1'b0, cfg_x0} + {1'b0, cfg_width} - {{W{1'b0}}, 1'b1};
  assign y_sum     = {1'b0, cfg_y0} + {1'b0, cfg_height} - {{W{1'b0}}, 1'b1};
  assign x_end_new = x_sum[W] ? {W{1'b1}} : x_sum[W-1:0];
  assign y_end_new = y_sum[W] ? {W{1'b1}} : y_sum[W-1:0];

  // Extra bit keeps X from wrapping: a carry always fails the x_end compare.
  assign x_nxt  = {1'b0, pix_x_q} + {{(W-3){1'b0}}, step_q};
  assign accept = (state_q == StRun) && pix_ready;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    step_d  = step_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok) begin
            x0_d    = cfg_x0;
            step_d  = cfg_step;
            x_end_d = x_end_new;
            y_end_d = y_end_new;
            pix_x_d = cfg_x0;
            pix_y_d = cfg_y0;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (accept && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (abort) begin
          state_d = StIdle;
        end else if (accept) begin
          if (x_nxt <= {1'b0, x_end_q}) begin
            pix_x_d = x_nxt[W-1:0];
          end else if (pix_y_q < y_end_q) begin
            pix_x_d = x0_q;
            pix_y_d = pix_y_q + {{(W-1){1'b0}}, 1'b1};
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x0_q    <= '0;
      step_q  <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      step_q  <= step_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pix_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  // An abort landing in the DONE cycle suppresses the pulse.
  assign done      = (state_q == StDone) && !abort;
  assign err       = err_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_cnt   = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized self-checking bench for pattern_scan_ctrl against a list-based window model.
module tb_pattern_scan_ctrl;

  localparam int W    = 12;
  localparam int CW   = 24;
  localparam int CMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  cfg_x0;
  logic [W-1:0]  cfg_y0;
  logic [W-1:0]  cfg_width;
  logic [W-1:0]  cfg_height;
  logic [1:0]    cfg_xmode;
  logic          pix_valid;
  logic          pix_ready;
  logic [W-1:0]  pix_x;
  logic [W-1:0]  pix_y;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] pix_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int last_cnt = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(
    .W  (W),
    .CW (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_xmode  (cfg_xmode),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pix_cnt    (pix_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, pix_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_x"}, pix_x, 0);
    check_eq({tag, "_y"}, pix_y, 0);
    check_eq({tag, "_cnt"}, pix_cnt, 0);
  endtask

  task automatic randomize_cfg();
    cfg_x0     = W'($urandom);
    cfg_y0     = W'($urandom);
    cfg_width  = W'($urandom);
    cfg_height = W'($urandom);
    cfg_xmode  = 2'($urandom);
  endtask

  // Runs one scan; abort_at > 0 aborts on that accept; inject issues a stray start mid-run.
  task automatic run_scan(input int x0, input int y0, input int w, input int h, input int mode,
                          input int rdy_pct, input int abort_at, input bit inject,
                          input bit abort_with_start);
    int qx[$];
    int qy[$];
    int xe, ye, step, total;
    int accepts = 0;
    int busy_cycles = 0;
    int px = 0, py = 0, lastx = 0, lasty = 0;
    bit fin = 0, stalled = 0, aborted = 0;

    step = (mode == 1) ? 1 : (mode == 2) ? 4 : 8;
    xe = (x0 + w - 1 > CMAX) ? CMAX : x0 + w - 1;
    ye = (y0 + h - 1 > CMAX) ? CMAX : y0 + h - 1;
    for (int y = y0; y <= ye; y++) begin
      for (int x = x0; x <= xe; x += step) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    end
    total = qx.size();

    @(negedge clk);
    cfg_x0     = W'(x0);
    cfg_y0     = W'(y0);
    cfg_width  = W'(w);
    cfg_height = W'(h);
    cfg_xmode  = 2'(mode);
    start      = 1'b1;
    abort      = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      pix_ready = ($urandom_range(99) < rdy_pct);
      start     = inject && (cyc == 2);
      randomize_cfg();
      #1;
      if (aborted) begin
        check_eq("abort_valid", pix_valid, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_cnt", pix_cnt, abort_at);
        last_cnt = abort_at;
        fin = 1;
      end else if (done) begin
        check_eq("done_valid", pix_valid, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_cnt", pix_cnt, total);
        check_eq("done_left", qx.size(), 0);
        check_eq("done_x_hold", pix_x, lastx);
        check_eq("done_y_hold", pix_y, lasty);
        if (rdy_pct >= 100) check_eq("busy_cycles", busy_cycles, total);
        last_cnt = total;
        fin = 1;
      end else begin
        check_eq("run_valid", pix_valid, 1);
        check_eq("run_busy", busy, 1);
        if (stalled) begin
          check_eq("stall_x", pix_x, px);
          check_eq("stall_y", pix_y, py);
        end
        if (pix_valid && pix_ready) begin
          if (qx.size() == 0) begin
            check_eq("extra_pixel", 1, 0);
          end else begin
            lastx = qx.pop_front();
            lasty = qy.pop_front();
            check_eq("pix_x", pix_x, lastx);
            check_eq("pix_y", pix_y, lasty);
          end
          accepts++;
          if (accepts == abort_at) begin
            abort   = 1'b1;
            aborted = 1;
          end
        end
        stalled = !pix_ready;
        px = pix_x;
        py = pix_y;
        busy_cycles++;
      end
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
    end
    if (!fin) begin
      check_eq("timeout", 0, 1);
    end else begin
      #1;
      check_eq("post_done", done, 0);
      check_eq("post_busy", busy, 0);
      check_eq("post_cnt", pix_cnt, last_cnt);
    end
  endtask

  task automatic reject(input int w, input int h, input int mode, input string tag);
    @(negedge clk);
    cfg_x0     = W'(7);
    cfg_y0     = W'(3);
    cfg_width  = W'(w);
    cfg_height = W'(h);
    cfg_xmode  = 2'(mode);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq({tag, "_err"}, err, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, pix_valid, 0);
    check_eq({tag, "_cnt"}, pix_cnt, last_cnt);
    @(negedge clk);
    #1;
    check_eq({tag, "_err_clr"}, err, 0);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pix_ready  = 1'b0;
    cfg_x0     = '0;
    cfg_y0     = '0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_xmode  = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_scan(10, 5, 9, 2, 2, 100, 0, 0, 0);
    run_scan(10, 5, 9, 2, 2, 50, 0, 0, 0);
    run_scan(4090, 0, 20, 1, 3, 100, 0, 0, 0);
    run_scan(0, 4094, 3, 5, 1, 100, 0, 0, 0);

    reject(9, 2, 0, "rej_mode");
    reject(0, 2, 2, "rej_width");
    reject(9, 0, 1, "rej_height");

    run_scan(10, 5, 9, 2, 2, 100, 0, 1, 0);
    run_scan(10, 5, 9, 2, 2, 100, 3, 0, 0);
    run_scan(10, 5, 9, 2, 2, 100, 0, 0, 1);

    // Reset mid-row, then a fresh scan must run normally.
    @(negedge clk);
    cfg_x0     = W'(10);
    cfg_y0     = W'(5);
    cfg_width  = W'(9);
    cfg_height = W'(2);
    cfg_xmode  = 2'b10;
    pix_ready  = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n    = 1'b1;
    last_cnt = 0;
    run_scan(10, 5, 9, 2, 2, 100, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int x0, y0;
      x0 = ($urandom_range(1) == 1) ? 4050 + $urandom_range(45) : $urandom_range(CMAX);
      y0 = ($urandom_range(1) == 1) ? 4092 + $urandom_range(3) : $urandom_range(CMAX);
      run_scan(x0, y0, 1 + $urandom_range(39), 1 + $urandom_range(3), 1 + $urandom_range(2),
               30 + $urandom_range(70), 0, $urandom_range(1), $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
